// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Purpose  : Shared types, constants and helpers for the PHT arbiter.
//            - ctr_t       : 2-bit saturating branch counter
//            - upd_entry_t : one queued resolve update (table index, outcome,
//                            and captured global history when
//                            BP_PHT_GSHARE_EN is defined)
//            - ctr_next()  : saturating counter update
// Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_RESET = 2'b01;
    localparam ctr_t CTR_MAX   = 2'b11;
    localparam ctr_t CTR_MIN   = 2'b00;

    // Widest index / history an entry can carry. Unused upper bits stay zero
    // and are removed by synthesis. Bounds ENTRIES to at most 2**16.
    localparam int IDX_MAX_W = 16;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        logic                 taken;
`ifdef BP_PHT_GSHARE_EN
        logic [IDX_MAX_W-1:0] hist;
`endif
    } upd_entry_t;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        if (taken && (c != CTR_MAX)) begin
            n = c + 2'd1;
        end else if (!taken && (c != CTR_MIN)) begin
            n = c - 2'd1;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_upd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bp_upd_fifo
// Purpose  : Synchronous FIFO holding pending resolve updates.
// Ports    : clk, rst_n (async active-low)
//            push/wdata : write request (ignored when full, no pop bypass)
//            pop/rdata  : pop request (ignored when empty), rdata = head
//            full, empty, count : occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module bp_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];

    // Full rejects a push even when a pop happens in the same cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_pht_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_pht_arbiter
// Purpose  : Pattern history table of 2-bit counters with one access slot per
//            cycle shared between fetch lookups and queued resolve updates.
//            Lookups win unless a pending update has lost STARVE_MAX times.
// Ports    : clk, rst_n (async active-low)
//            lk_valid/lk_ready/lk_pc       : lookup request
//            pred_valid/pred_taken         : prediction, one cycle later
//            up_valid/up_ready/up_pc/up_taken : resolve update push
//            busy                          : update FIFO non-empty
// Options  : BP_PHT_GSHARE_EN - XOR a HIST_W-bit global history into the
//            table index (history captured per entry at push time).
// Revision : 1.0 - initial release
// ============================================================================
module bp_pht_arbiter
    import bp_pkg::*;
#(
    parameter int ENTRIES    = 16,
    parameter int PC_W       = 32,
    parameter int UPD_DEPTH  = 4,
    parameter int STARVE_MAX = 3,
    parameter int HIST_W     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lk_valid,
    output logic            lk_ready,
    input  logic [PC_W-1:0] lk_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    input  logic            up_valid,
    output logic            up_ready,
    input  logic [PC_W-1:0] up_pc,
    input  logic            up_taken,
    output logic            busy
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int SW    = $clog2(STARVE_MAX + 1);
    localparam int CW    = $clog2(UPD_DEPTH) + 1;
    localparam int ENT_W = $bits(upd_entry_t);

    ctr_t              r_pht [ENTRIES];
    logic [SW-1:0]     r_starve;
    logic              r_pred_valid;
    logic              r_pred_taken;

    upd_entry_t        w_push_ent;
    upd_entry_t        w_head;
    logic [ENT_W-1:0]  w_head_bits;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CW-1:0]     w_fifo_count;
    logic              w_push;
    logic              w_force;
    logic              w_do_lk;
    logic              w_do_up;
    logic [IDX_W-1:0]  w_lk_idx;
    logic [IDX_W-1:0]  w_up_idx;
    logic              w_unused;

`ifdef BP_PHT_GSHARE_EN
    logic [HIST_W-1:0] r_ghr;

    assign w_lk_idx = lk_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);
    assign w_up_idx = w_head.idx[IDX_W-1:0] ^ IDX_W'(w_head.hist[HIST_W-1:0]);
    assign w_unused = ^{lk_pc[PC_W-1:IDX_W+2], lk_pc[1:0],
                        up_pc[PC_W-1:IDX_W+2], up_pc[1:0],
                        w_head.idx[IDX_MAX_W-1:IDX_W],
                        w_head.hist[IDX_MAX_W-1:HIST_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (w_push) begin
            r_ghr <= {r_ghr[HIST_W-2:0], up_taken};
        end
    end
`else
    assign w_lk_idx = lk_pc[IDX_W+1:2];
    assign w_up_idx = w_head.idx[IDX_W-1:0];
    assign w_unused = ^{lk_pc[PC_W-1:IDX_W+2], lk_pc[1:0],
                        up_pc[PC_W-1:IDX_W+2], up_pc[1:0],
                        w_head.idx[IDX_MAX_W-1:IDX_W]};
`endif

    always_comb begin
        w_push_ent       = '0;
        w_push_ent.idx   = IDX_MAX_W'(up_pc[IDX_W+1:2]);
        w_push_ent.taken = up_taken;
`ifdef BP_PHT_GSHARE_EN
        w_push_ent.hist  = IDX_MAX_W'(r_ghr);
`endif
    end

    assign w_head = w_head_bits;

    // Slot arbitration: forced update, else lookup, else idle update.
    assign w_force  = !w_fifo_empty && (r_starve == SW'(STARVE_MAX));
    assign lk_ready = !w_force;
    assign w_do_lk  = lk_valid && !w_force;
    assign w_do_up  = !w_fifo_empty && !w_do_lk;

    assign up_ready = !w_fifo_full;
    assign w_push   = up_valid && !w_fifo_full;
    assign busy     = (w_fifo_count != '0);

    assign pred_valid = r_pred_valid;
    assign pred_taken = r_pred_taken;

    bp_upd_fifo #(
        .DEPTH (UPD_DEPTH),
        .WIDTH (ENT_W)
    ) u_upd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (w_push_ent),
        .pop   (w_do_up),
        .rdata (w_head_bits),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve     <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_pht[i] <= CTR_RESET;
            end
        end else begin
            // Starve only accumulates while an update waits and loses.
            if (w_fifo_empty || w_do_up) begin
                r_starve <= '0;
            end else begin
                r_starve <= r_starve + SW'(1);
            end

            r_pred_valid <= w_do_lk;
            if (w_do_lk) begin
                r_pred_taken <= r_pht[w_lk_idx][1];
            end

            if (w_do_up) begin
                r_pht[w_up_idx] <= ctr_next(r_pht[w_up_idx], w_head.taken);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_pht_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_pht_arbiter
// Purpose  : Directed self-checking bench for bp_pht_arbiter (default build:
//            ENTRIES=16, UPD_DEPTH=4, STARVE_MAX=3, plain PC indexing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_pht_arbiter;

    logic        clk;
    logic        rst_n;
    logic        lk_valid;
    logic        lk_ready;
    logic [31:0] lk_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic        up_valid;
    logic        up_ready;
    logic [31:0] up_pc;
    logic        up_taken;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    bp_pht_arbiter #(
        .ENTRIES    (16),
        .PC_W       (32),
        .UPD_DEPTH  (4),
        .STARVE_MAX (3),
        .HIST_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lk_valid   (lk_valid),
        .lk_ready   (lk_ready),
        .lk_pc      (lk_pc),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_pc      (up_pc),
        .up_taken   (up_taken),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the update FIFO to drain.
    task automatic drain(input string tag);
        for (int i = 0; i < 20 && busy; i++) tick();
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    // Push one update with lookups idle, then let it be applied.
    task automatic push_upd(input logic [31:0] pc, input logic t);
        up_valid = 1'b1;
        up_pc    = pc;
        up_taken = t;
        tick();
        up_valid = 1'b0;
        drain("drain_upd");
    endtask

    // One accepted lookup; prediction checked the following cycle.
    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
        lk_valid = 1'b1;
        lk_pc    = pc;
        tick();
        lk_valid = 1'b0;
        check({tag, "_pv"}, {31'd0, pred_valid}, 32'd1);
        check({tag, "_pt"}, {31'd0, pred_taken}, {31'd0, exp});
    endtask

    initial begin
        rst_n    = 1'b0;
        lk_valid = 1'b0;
        lk_pc    = '0;
        up_valid = 1'b0;
        up_pc    = '0;
        up_taken = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_lk_ready",   {31'd0, lk_ready},   32'd1);
        check("rst_up_ready",   {31'd0, up_ready},   32'd1);
        rst_n = 1'b1;
        tick();

        // First lookup: weakly not-taken, valid for exactly one cycle
        lookup("lk40_init", 32'h40, 1'b0);
        tick();
        check("pv_pulse", {31'd0, pred_valid}, 32'd0);
        check("pt_hold",  {31'd0, pred_taken}, 32'd0);

        // Saturating counter at idx 0: 01 -> 10 -> 11 -> (11) -> 10 -> 01 -> 00 ...
        push_upd(32'h40, 1'b1);
        push_upd(32'h40, 1'b1);
        lookup("lk40_c3", 32'h40, 1'b1);
        push_upd(32'h40, 1'b1);             // stays 3
        push_upd(32'h40, 1'b0);             // 2
        lookup("lk40_sat_hi", 32'h40, 1'b1);
        push_upd(32'h40, 1'b0);             // 1
        lookup("lk40_c1", 32'h40, 1'b0);
        push_upd(32'h40, 1'b0);             // 0
        push_upd(32'h40, 1'b0);             // stays 0
        push_upd(32'h40, 1'b1);             // 1
        lookup("lk40_sat_lo", 32'h40, 1'b0);
        push_upd(32'h40, 1'b1);             // 2
        lookup("lk40_c2", 32'h40, 1'b1);

        // FIFO fill with lookups holding the slot: 4 accepted, 5th refused
        lk_valid = 1'b1;
        lk_pc    = 32'h48;
        up_valid = 1'b1;
        up_taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_pc = 32'h60 + 32'(i * 4);
            check("fill_up_ready", {31'd0, up_ready}, 32'd1);
            tick();
        end
        up_pc = 32'h70;
        check("full_up_ready", {31'd0, up_ready}, 32'd0);
        check("full_busy",     {31'd0, busy},     32'd1);
        check("full_forced",   {31'd0, lk_ready}, 32'd0);
        up_valid = 1'b0;
        lk_valid = 1'b0;
        drain("drain_full");
        // Rejected 5th push must not have been queued (idx 12 still weak NT)
        lookup("lk70_rejected", 32'h70, 1'b0);

        // Starvation: one queued update, lookups held every cycle
        lk_valid = 1'b1;
        lk_pc    = 32'h48;
        up_valid = 1'b1;
        up_pc    = 32'h70;
        up_taken = 1'b1;
        tick();
        up_valid = 1'b0;
        check("starve_c0", {31'd0, lk_ready}, 32'd1);
        tick();
        check("starve_c1", {31'd0, lk_ready}, 32'd1);
        tick();
        check("starve_c2", {31'd0, lk_ready}, 32'd1);
        tick();
        check("starve_force", {31'd0, lk_ready}, 32'd0);
        tick();
        check("starve_after",   {31'd0, lk_ready},   32'd1);
        check("starve_no_pred", {31'd0, pred_valid}, 32'd0);
        check("starve_busy",    {31'd0, busy},       32'd0);
        lk_valid = 1'b0;
        lookup("lk70_forced", 32'h70, 1'b1);

        // Push and lookup to the same index in one cycle: pre-update value
        lk_valid = 1'b1;
        lk_pc    = 32'h44;
        up_valid = 1'b1;
        up_pc    = 32'h44;
        up_taken = 1'b1;
        tick();
        lk_valid = 1'b0;
        up_valid = 1'b0;
        check("same_cyc_pv", {31'd0, pred_valid}, 32'd1);
        check("same_cyc_pt", {31'd0, pred_taken}, 32'd0);
        drain("drain_same");
        lookup("lk44_after", 32'h44, 1'b1);

        // Reset with three queued updates
        lk_valid = 1'b1;
        lk_pc    = 32'h44;
        up_valid = 1'b1;
        up_pc    = 32'h40;
        up_taken = 1'b1;
        tick();
        tick();
        tick();
        up_valid = 1'b0;
        check("q3_busy",      {31'd0, busy},       32'd1);
        check("q3_pred_high", {31'd0, pred_taken}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy},       32'd0);
        check("mid_rst_pv",   {31'd0, pred_valid}, 32'd0);
        check("mid_rst_pt",   {31'd0, pred_taken}, 32'd0);
        lk_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        lookup("lk40_rst", 32'h40, 1'b0);
        lookup("lk44_rst", 32'h44, 1'b0);
        lookup("lk70_rst", 32'h70, 1'b0);
        lookup("lk60_rst", 32'h60, 1'b0);
        // Counter really is 01: one taken update must flip the prediction
        push_upd(32'h60, 1'b1);
        lookup("lk60_rst_plus1", 32'h60, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_pht_arbiter.md
Name: bp_pht_arbiter

Overview:
- Owns a pattern history table (PHT) of 2-bit saturating branch counters and shares its single access slot between fetch-side lookups and execute-side resolve updates.
- Resolve updates are buffered in a small FIFO. Lookups have priority, and a starvation limit forces updates through.
- Sits between the fetch stage (prediction consumer) and the branch resolution unit (outcome producer).

Parameters:
- ENTRIES, 16: number of PHT counters; power of two, ≥2. IDX_W = $clog2(ENTRIES).
- PC_W, 32: program counter width.
- UPD_DEPTH, 4: update FIFO depth; power of two, ≥2.
- STARVE_MAX, 3: maximum consecutive cycles a pending update may lose arbitration; ≥1.
- HIST_W, 4: global history length, used only with the optional feature; ≤IDX_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- lk_valid  in  1  lookup request.
- lk_ready  out  1  lookup accepted this cycle when lk_valid && lk_ready.
- lk_pc  in  PC_W  branch PC to predict.
- pred_valid  out  1  prediction available; one-cycle pulse.
- pred_taken  out  1  predicted direction (counter MSB).
- up_valid  in  1  resolve update offered.
- up_ready  out  1  update FIFO not full.
- up_pc  in  PC_W  resolved branch PC.
- up_taken  in  1  resolved direction.
- busy  out  1  FIFO non-empty.

Behaviour:
- Reset (async, rst_n=0):
  - all counters = 2'b01 (weakly not-taken)
  - FIFO empty; starve counter = 0
  - pred_valid = 0, pred_taken = 0, busy = 0
  - GHR = 0 when the optional feature is enabled
- Reset asserted mid-operation discards queued updates and any in-flight prediction.
- Index: idx = pc[IDX_W+1:2]. Bits [1:0] are ignored.
- One table access per cycle. The slot is granted as follows:
  - FORCE when FIFO non-empty and starve == STARVE_MAX: update slot; lk_ready = 0.
  - Otherwise, when lk_valid = 1: lookup slot; lk_ready = 1.
  - Otherwise, when FIFO non-empty: update slot.
  - Otherwise: idle.
- lk_ready is combinational from the FIFO-empty flag and starve only; it never depends on lk_valid.
- Starve counter:
  - increments each cycle the FIFO is non-empty and the update does not get the slot
  - clears whenever an update is performed or the FIFO is empty
- Lookup latency is 1 cycle. The cycle after acceptance: pred_valid = 1, pred_taken = counter[idx][1]. Otherwise pred_valid = 0 and pred_taken holds its last value.
- Update slot pops the FIFO head and applies a saturating update:
  - taken && ctr != 3: ctr + 1
  - !taken && ctr != 0: ctr − 1
  - otherwise: ctr unchanged
  - The write is visible to a lookup in the following cycle.
- No forwarding: a lookup to an index with queued updates reads the current table value.
- FIFO:
  - push when up_valid && up_ready
  - up_ready = !full, with no pop bypass; a full FIFO rejects a push even in the cycle it pops
  - simultaneous push and pop when non-full keeps the count unchanged
  - FIFO order is preserved; pointers wrap modulo UPD_DEPTH
- busy = (count != 0).

Optional Feature:
- Macro: BP_PHT_GSHARE_EN.
- With the macro defined:
  - adds a HIST_W-bit global history register (GHR).
  - Lookup index = pc[IDX_W+1:2] XOR zero-extended GHR.
  - Update index = up_pc[IDX_W+1:2] XOR the GHR value captured with the entry at push time; each FIFO entry stores HIST_W extra bits.
  - On each push, GHR ← {GHR[HIST_W-2:0], up_taken}.
- Without the macro: no GHR, no extra FIFO bits, plain PC indexing.

Decomposition:
- Package bp_pkg:
  - counter typedef (2-bit)
  - constants CTR_RESET = 2'b01, CTR_MAX = 3, CTR_MIN = 0
  - update-entry struct {pc index, taken, optional history}
- One sub-module: bp_upd_fifo, a synchronous FIFO with full/empty/count outputs, parameterised by depth and entry width.
- Arbitration, starve counter and PHT array stay in the top module.

Test Plan (ENTRIES=16, UPD_DEPTH=4, STARVE_MAX=3):
- Reset, then lookup pc=0x40 → next cycle pred_valid=1, pred_taken=0.
- Two updates pc=0x40 taken, idle until busy=0, lookup 0x40 → pred_taken=1 (ctr=3); a third taken update leaves ctr=3 (saturates). Then four not-taken updates → ctr=0; a further one keeps 0.
- 5 back-to-back pushes with no pops (lk_valid held 1) → first 4 accepted, 5th sees up_ready=0; FIFO remains at 4.
- lk_valid held 1 with one queued update → lk_ready=1 for 3 cycles, then 0 for exactly one cycle (forced update), then 1.
- Push pc=0x44 taken and lookup 0x44 in the same cycle → prediction uses pre-update value 0.
- Reset asserted with 3 queued entries → busy=0 immediately and all counters read 2'b01. With BP_PHT_GSHARE_EN: after updates taken, taken, the GHR is 4'b0011, and lookup pc=0x40 reads index 0 XOR 3 = 3.
